// File: rtl/apb2axi_txn_mgr.sv
// rtl/apb2axi_txn_mgr.sv - pops PENDING directory entries and issues them as AXI4 AR/AW address beats
// Tracks outstanding reads/writes per direction and throttles pops at MAX_OUTST_P.
module apb2axi_txn_mgr #(
    parameter int TAG_W_P      = 4,
    parameter int MAX_OUTST_P  = 4,
    parameter int CNT_W_P      = 4,
    parameter int AXI_ADDR_W_P = 32,
    parameter int DIR_ST_W_P   = 2
) (
    input  logic                                         pclk,
    input  logic                                         presetn,
    input  logic                                         pending_valid,
    input  logic [AXI_ADDR_W_P+TAG_W_P+DIR_ST_W_P+13:0]  pending_entry,
    input  logic [TAG_W_P-1:0]                           pending_tag,
    output logic                                         pending_pop,
    output logic                                         ar_valid,
    input  logic                                         ar_ready,
    output logic [TAG_W_P-1:0]                           ar_id,
    output logic [AXI_ADDR_W_P-1:0]                      ar_addr,
    output logic [7:0]                                   ar_len,
    output logic [2:0]                                   ar_size,
    output logic [1:0]                                   ar_burst,
    output logic                                         aw_valid,
    input  logic                                         aw_ready,
    output logic [TAG_W_P-1:0]                           aw_id,
    output logic [AXI_ADDR_W_P-1:0]                      aw_addr,
    output logic [7:0]                                   aw_len,
    output logic [2:0]                                   aw_size,
    output logic [1:0]                                   aw_burst,
    input  logic                                         rd_done,
    input  logic                                         wr_done,
    output logic [CNT_W_P-1:0]                           rd_outst,
    output logic [CNT_W_P-1:0]                           wr_outst,
    output logic                                         busy,
    output logic                                         err_4k,
    output logic                                         err_underflow
);

    // Entry layout, MSB..LSB: {addr, len, size, burst, is_write, tag, state}
    localparam int TAG_LSB   = DIR_ST_W_P;
    localparam int WR_BIT    = DIR_ST_W_P + TAG_W_P;
    localparam int BURST_LSB = WR_BIT + 1;
    localparam int SIZE_LSB  = WR_BIT + 3;
    localparam int LEN_LSB   = WR_BIT + 6;
    localparam int ADDR_LSB  = WR_BIT + 14;
    localparam logic [CNT_W_P-1:0] MAX_CNT = CNT_W_P'(MAX_OUTST_P);
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE_AR, ISSUE_AW} state_t;
    state_t state;

    logic [AXI_ADDR_W_P-1:0] e_addr;
    logic [7:0]              e_len;
    logic [2:0]              e_size;
    logic [1:0]              e_burst;
    logic                    e_write;
    logic [20:0]             e_bytes;
    logic [20:0]             e_end;
    logic                    e_cross;
    logic                    rd_issue;
    logic                    wr_issue;
    logic                    entry_unused;

    assign e_addr  = pending_entry[ADDR_LSB +: AXI_ADDR_W_P];
    assign e_len   = pending_entry[LEN_LSB +: 8];
    assign e_size  = pending_entry[SIZE_LSB +: 3];
    assign e_burst = pending_entry[BURST_LSB +: 2];
    assign e_write = pending_entry[WR_BIT];
    // Tag comes from pending_tag and state is implied by pending_valid.
    assign entry_unused = ^{pending_entry[TAG_LSB +: TAG_W_P], pending_entry[DIR_ST_W_P-1:0]};

    assign e_bytes = ({13'd0, e_len} + 21'd1) << e_size;
    assign e_end   = {9'd0, e_addr[11:0]} + e_bytes;
    assign e_cross = (e_burst == BURST_INCR) && (e_end > 21'd4096);

    // Head-of-line: a blocked direction stalls the whole queue.
    assign pending_pop = (state == IDLE) && pending_valid &&
                         (e_write ? (wr_outst < MAX_CNT) : (rd_outst < MAX_CNT));

    assign rd_issue = ar_valid && ar_ready;
    assign wr_issue = aw_valid && aw_ready;

    function automatic logic [CNT_W_P-1:0] next_cnt(input logic [CNT_W_P-1:0] cnt,
                                                   input logic inc, input logic dec);
        logic [CNT_W_P-1:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            r = cnt - 1'b1;
        return r;
    endfunction

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            ar_valid      <= 1'b0;
            ar_id         <= '0;
            ar_addr       <= '0;
            ar_len        <= '0;
            ar_size       <= '0;
            ar_burst      <= '0;
            aw_valid      <= 1'b0;
            aw_id         <= '0;
            aw_addr       <= '0;
            aw_len        <= '0;
            aw_size       <= '0;
            aw_burst      <= '0;
            rd_outst      <= '0;
            wr_outst      <= '0;
            err_4k        <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rd_outst <= next_cnt(rd_outst, rd_issue, rd_done);
            wr_outst <= next_cnt(wr_outst, wr_issue, wr_done);
            if ((rd_done && !rd_issue && rd_outst == '0) ||
                (wr_done && !wr_issue && wr_outst == '0))
                err_underflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending_pop) begin
                        busy <= 1'b1;
                        if (e_cross)
                            err_4k <= 1'b1;
                        if (e_write) begin
                            state    <= ISSUE_AW;
                            aw_valid <= 1'b1;
                            aw_id    <= pending_tag;
                            aw_addr  <= e_addr;
                            aw_len   <= e_len;
                            aw_size  <= e_size;
                            aw_burst <= e_burst;
                        end else begin
                            state    <= ISSUE_AR;
                            ar_valid <= 1'b1;
                            ar_id    <= pending_tag;
                            ar_addr  <= e_addr;
                            ar_len   <= e_len;
                            ar_size  <= e_size;
                            ar_burst <= e_burst;
                        end
                    end
                end
                ISSUE_AR: begin
                    if (ar_ready) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ar_valid <= 1'b0;
                    end
                end
                ISSUE_AW: begin
                    if (aw_ready) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        aw_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi_txn_mgr.sv
// tb/tb_apb2axi_txn_mgr.sv - scoreboard bench for apb2axi_txn_mgr
module tb_apb2axi_txn_mgr;
    localparam int TAG_W = 4;
    localparam int ADDR_W = 32;
    localparam int ENTRY_W = ADDR_W + TAG_W + 2 + 14;
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [TAG_W-1:0]  tag;
    } txn_t;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic pending_valid = 1'b0;
    logic [ENTRY_W-1:0] pending_entry = '0;
    logic [TAG_W-1:0] pending_tag = '0;
    logic pending_pop;
    logic ar_valid, ar_ready = 1'b0;
    logic [TAG_W-1:0] ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0] ar_len;
    logic [2:0] ar_size;
    logic [1:0] ar_burst;
    logic aw_valid, aw_ready = 1'b0;
    logic [TAG_W-1:0] aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0] aw_len;
    logic [2:0] aw_size;
    logic [1:0] aw_burst;
    logic rd_done = 1'b0, wr_done = 1'b0;
    logic [3:0] rd_outst, wr_outst;
    logic busy, err_4k, err_underflow;

    int n_cmp = 0;
    int n_fail = 0;
    txn_t ar_q[$];
    txn_t aw_q[$];
    txn_t mon_exp, mon_got;

    apb2axi_txn_mgr #(.TAG_W_P(TAG_W), .MAX_OUTST_P(4), .CNT_W_P(4),
                      .AXI_ADDR_W_P(ADDR_W), .DIR_ST_W_P(2)) dut (
        .pclk(pclk), .presetn(presetn),
        .pending_valid(pending_valid), .pending_entry(pending_entry),
        .pending_tag(pending_tag), .pending_pop(pending_pop),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .rd_done(rd_done), .wr_done(wr_done), .rd_outst(rd_outst), .wr_outst(wr_outst),
        .busy(busy), .err_4k(err_4k), .err_underflow(err_underflow)
    );

    always #5 pclk = ~pclk;

    // Address-channel monitor: every handshake must match the oldest expected txn.
    always begin
        @(negedge pclk);
        #2;
        if (presetn) begin
            if (ar_valid && ar_ready) begin
                n_cmp++;
                if (ar_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_unexpected: got id=%0d addr=%h, required no AR", ar_id, ar_addr);
                end else begin
                    mon_exp = ar_q.pop_front();
                    mon_got = {ar_addr, ar_len, ar_size, ar_burst, ar_id};
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL ar_txn: got %h, required %h", mon_got, mon_exp);
                    end
                end
            end
            if (aw_valid && aw_ready) begin
                n_cmp++;
                if (aw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_unexpected: got id=%0d addr=%h, required no AW", aw_id, aw_addr);
                end else begin
                    mon_exp = aw_q.pop_front();
                    mon_got = {aw_addr, aw_len, aw_size, aw_burst, aw_id};
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL aw_txn: got %h, required %h", mon_got, mon_exp);
                    end
                end
            end
        end
    end

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [31:0] addr, input logic [7:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst,
                                                    input logic wr, input logic [3:0] tag);
        return {addr, len, size, burst, wr, tag, 2'b01};
    endfunction

    // Presents an entry, waits for the pop and records the expected address beat.
    // Returns at the negedge following the pop edge, when x_valid should be high.
    task automatic offer(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic wr, input logic [3:0] tag);
        int n = 0;
        @(negedge pclk);
        pending_valid = 1'b1;
        pending_entry = mk_entry(addr, len, size, burst, wr, tag);
        pending_tag = tag;
        #1;
        while (!pending_pop && n < 50) begin
            @(negedge pclk);
            #1;
            n++;
        end
        n_cmp++;
        if (!pending_pop) begin
            n_fail++;
            $display("FAIL pop_timeout: got pending_pop=0 after %0d cycles, required 1", n);
        end else if (wr) aw_q.push_back({addr, len, size, burst, tag});
        else ar_q.push_back({addr, len, size, burst, tag});
        @(negedge pclk);
        pending_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge pclk);
        n_cmp++;
        if ({ar_valid, aw_valid, busy, err_4k, err_underflow, pending_pop} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {ar_valid, aw_valid, busy, err_4k, err_underflow, pending_pop});
        end
        n_cmp++;
        if ({rd_outst, wr_outst} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_counters: got %h, required 00", {rd_outst, wr_outst});
        end
        n_cmp++;
        if ({ar_addr, aw_addr, ar_id, aw_id, ar_len, aw_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got ar_addr=%h aw_addr=%h, required 0", ar_addr, aw_addr);
        end
        presetn = 1'b1;
    endtask

    task automatic test_read;
        ar_ready = 1'b1;
        offer(32'h1000, 8'd3, 3'd2, INCR, 1'b0, 4'd5);
        n_cmp++;
        if ({ar_valid, busy, ar_id, ar_len} !== {1'b1, 1'b1, 4'd5, 8'd3}) begin
            n_fail++;
            $display("FAIL read_issue: got valid=%b busy=%b id=%0d len=%0d, required 1 1 5 3",
                     ar_valid, busy, ar_id, ar_len);
        end
        @(negedge pclk);
        n_cmp++;
        if ({ar_valid, busy, rd_outst, err_4k} !== {1'b0, 1'b0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL read_done: got valid=%b busy=%b rd_outst=%0d err_4k=%b, required 0 0 1 0",
                     ar_valid, busy, rd_outst, err_4k);
        end
    endtask

    task automatic test_backpressure;
        aw_ready = 1'b0;
        offer(32'h2000, 8'd7, 3'd2, INCR, 1'b1, 4'd9);
        pending_valid = 1'b1;
        pending_entry = mk_entry(32'h2100, 8'd0, 3'd2, INCR, 1'b0, 4'd2);
        pending_tag = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({aw_valid, aw_addr, aw_len, aw_id, pending_pop} !== {1'b1, 32'h2000, 8'd7, 4'd9, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b addr=%h len=%0d id=%0d pop=%b, required 1 2000 7 9 0",
                         i, aw_valid, aw_addr, aw_len, aw_id, pending_pop);
            end
            @(negedge pclk);
        end
        pending_valid = 1'b0;
        aw_ready = 1'b1;
        @(negedge pclk);
        n_cmp++;
        if ({aw_valid, wr_outst} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b wr_outst=%0d, required 0 1", aw_valid, wr_outst);
        end
    endtask

    task automatic test_throttle;
        for (int i = 0; i < 3; i++)
            offer(32'h3000 + 32'(i * 16), 8'd0, 3'd2, INCR, 1'b0, 4'(i + 1));
        @(negedge pclk);
        n_cmp++;
        if (rd_outst !== 4'd4) begin
            n_fail++;
            $display("FAIL thr_full: got rd_outst=%0d, required 4", rd_outst);
        end
        pending_valid = 1'b1;
        pending_entry = mk_entry(32'h4000, 8'd1, 3'd2, INCR, 1'b0, 4'd8);
        pending_tag = 4'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (pending_pop !== 1'b0) begin
                n_fail++;
                $display("FAIL thr_block[%0d]: got pending_pop=%b, required 0", i, pending_pop);
            end
            @(negedge pclk);
        end
        rd_done = 1'b1;
        @(negedge pclk);
        rd_done = 1'b0;
        #1;
        n_cmp++;
        if ({pending_pop, rd_outst} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL thr_unblock: got pop=%b rd_outst=%0d, required 1 3", pending_pop, rd_outst);
        end else ar_q.push_back({32'h4000, 8'd1, 3'd2, INCR, 4'd8});
        @(negedge pclk);
        pending_valid = 1'b0;
        @(negedge pclk);
        n_cmp++;
        if (rd_outst !== 4'd4) begin
            n_fail++;
            $display("FAIL thr_refill: got rd_outst=%0d, required 4", rd_outst);
        end
    endtask

    task automatic test_simultaneous;
        rd_done = 1'b1;
        repeat (2) @(negedge pclk);
        rd_done = 1'b0;
        n_cmp++;
        if (rd_outst !== 4'd2) begin
            n_fail++;
            $display("FAIL sim_drain: got rd_outst=%0d, required 2", rd_outst);
        end
        offer(32'h5000, 8'd0, 3'd1, INCR, 1'b0, 4'd10);
        rd_done = 1'b1;
        @(negedge pclk);
        rd_done = 1'b0;
        n_cmp++;
        if ({ar_valid, rd_outst} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL sim_net: got valid=%b rd_outst=%0d, required 0 2", ar_valid, rd_outst);
        end
    endtask

    task automatic test_errors;
        rd_done = 1'b1;
        repeat (2) @(negedge pclk);
        rd_done = 1'b0;
        offer(32'h0FF0, 8'd1, 3'd3, INCR, 1'b0, 4'd11);
        n_cmp++;
        if (err_4k !== 1'b0) begin
            n_fail++;
            $display("FAIL e4k_exact: got err_4k=%b, required 0", err_4k);
        end
        offer(32'h0FF0, 8'd3, 3'd3, FIXED, 1'b0, 4'd12);
        n_cmp++;
        if (err_4k !== 1'b0) begin
            n_fail++;
            $display("FAIL e4k_fixed: got err_4k=%b, required 0", err_4k);
        end
        offer(32'h0FF0, 8'd3, 3'd3, INCR, 1'b0, 4'd7);
        n_cmp++;
        if ({err_4k, ar_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL e4k_cross: got err_4k=%b valid=%b, required 1 1", err_4k, ar_valid);
        end
        @(negedge pclk);
        n_cmp++;
        if (rd_outst !== 4'd3) begin
            n_fail++;
            $display("FAIL e4k_count: got rd_outst=%0d, required 3", rd_outst);
        end
        wr_done = 1'b1;
        @(negedge pclk);
        wr_done = 1'b0;
        n_cmp++;
        if ({wr_outst, err_underflow} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL uf_normal: got wr_outst=%0d uf=%b, required 0 0", wr_outst, err_underflow);
        end
        wr_done = 1'b1;
        @(negedge pclk);
        wr_done = 1'b0;
        n_cmp++;
        if ({wr_outst, err_underflow} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL uf_set: got wr_outst=%0d uf=%b, required 0 1", wr_outst, err_underflow);
        end
    endtask

    task automatic test_reset_mid_aw;
        aw_ready = 1'b0;
        offer(32'h6000, 8'd0, 3'd2, INCR, 1'b1, 4'd3);
        n_cmp++;
        if (aw_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got aw_valid=%b, required 1", aw_valid);
        end
        #1;
        presetn = 1'b0;
        #1;
        n_cmp++;
        if ({aw_valid, busy, rd_outst, wr_outst, err_4k, err_underflow} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b busy=%b rd=%0d wr=%0d e4k=%b uf=%b, required all 0",
                     aw_valid, busy, rd_outst, wr_outst, err_4k, err_underflow);
        end
        aw_q.delete();
        @(negedge pclk);
        presetn = 1'b1;
        aw_ready = 1'b1;
        offer(32'h7000, 8'd1, 3'd2, INCR, 1'b1, 4'd6);
        @(negedge pclk);
        n_cmp++;
        if ({aw_valid, wr_outst} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL rst_recover: got valid=%b wr_outst=%0d, required 0 1", aw_valid, wr_outst);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_backpressure();
        test_throttle();
        test_simultaneous();
        test_errors();
        test_reset_mid_aw();
        repeat (2) @(negedge pclk);
        n_cmp++;
        if (ar_q.size() + aw_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d AR + %0d AW never issued, required 0", ar_q.size(), aw_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
